hazard_controller: RTL

- Hazard and sequencing unit for the 5-stage pipeline.
- Drives the stall and flush controls of the F/D, D/E and E/M pipeline registers.
- Drives the operand-forwarding selects for the execute stage.
- Contains a multi-cycle execute FSM that holds the D/E register while a long-latency op (e.g. MUL) occupies execute.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/mc_busy_counter.sv | 79 +++++++
 rtl/hazard_controller.sv | 107 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   FWD_*        : execute-stage operand select encodings
//   mc_state_t   : multi-cycle execute FSM states
//   PC_REG_DEF   : default register index of the PC
//   MC_LAT_DEF   : default execute latency of a multi-cycle op
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value
  localparam logic [1:0] FWD_WB  = 2'b01;  // W-stage result
  localparam logic [1:0] FWD_MEM = 2'b10;  // M-stage ALU result

  localparam int PC_REG_DEF = 15;
  localparam int MC_LAT_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_t;

endpackage

// File: rtl/mc_busy_counter.sv
// Multi-cycle execute sequencer. Holds the D/E register while a long-latency
// op occupies execute, so the op spends MC_LAT cycles in E in total.
// Ports:
//   CLK, RST           : clock, synchronous active-low reset
//   i_multi_cycle      : E-stage instruction is a multi-cycle op
//   i_branch_taken     : branch resolved taken in E (blocks entry only)
//   o_busy             : hold request (entry cycle and every BUSY cycle)
//   o_dbg_busy_state   : 1 while the FSM is in BUSY
module mc_busy_counter
  import hazard_pkg::*;
#(
  parameter int MC_LAT = MC_LAT_DEF,
  parameter int CNT_W  = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic i_multi_cycle,
  input  logic i_branch_taken,
  output logic o_busy,
  output logic o_dbg_busy_state
);

  mc_state_t        r_state;
  mc_state_t        w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_done;
  logic             w_done_next;

  // The entry cycle is a hold cycle too, and the BUSY cycles cover the
  // remaining MC_LAT-2 holds. cnt reaches 0 on the step that returns to
  // IDLE; that IDLE cycle is the op's final, non-stalled E cycle, and the
  // done flag keeps the still-asserted MultiCycleE from restarting the FSM.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_multi_cycle && !i_branch_taken && !r_done) begin
          o_busy = 1'b1;
          if (MC_LAT == 2) begin
            w_done_next = 1'b1;
          end else begin
            w_state_next = BUSY;
            w_cnt_next   = CNT_W'(MC_LAT - 2);
          end
        end
      end
      BUSY: begin
        o_busy     = 1'b1;
        w_cnt_next = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_done_next;
    end
  end

  assign o_dbg_busy_state = (r_state == BUSY);

endmodule

// File: rtl/hazard_controller.sv
// Hazard and sequencing unit for the 5-stage pipeline.
// Ports:
//   CLK, RST                   : clock, synchronous active-low reset
//   RA1D/RA2D, RA1E/RA2E       : source registers in decode / execute
//   WA3E/WA3M/WA3W, RegWrite*  : destination register and write enable per stage
//   MemtoRegE, MultiCycleE     : E-stage op is a load / a multi-cycle op
//   BranchTakenE               : branch resolved taken in execute
//   ForwardAE/ForwardBE        : execute operand selects (see hazard_pkg)
//   StallF/StallD/StallE       : hold PC+F/D, F/D, D/E
//   FlushD/FlushE/FlushM       : bubble into F/D, D/E, E/M
//   BusyE                      : multi-cycle op holding execute
//   o_dbg_mc_busy              : multi-cycle FSM is in BUSY (debug)
// Priority: branch flush > multi-cycle hold > load-use stall, except that an
// op already in BUSY ignores branches.
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int REG_W  = 4,
  parameter int PC_REG = PC_REG_DEF,
  parameter int MC_LAT = MC_LAT_DEF,
  parameter int CNT_W  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] RA1E,
  input  logic [REG_W-1:0] RA2E,
  input  logic [REG_W-1:0] WA3E,
  input  logic [REG_W-1:0] WA3M,
  input  logic [REG_W-1:0] WA3W,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MultiCycleE,
  input  logic             BranchTakenE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             BusyE,
  output logic             o_dbg_mc_busy
);

  localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

  logic w_match_m_a, w_match_w_a, w_match_m_b, w_match_w_b;
  logic w_ld_stall;
  logic w_busy;

  // The PC is read from the fetch path, never from a forwarded result.
  assign w_match_m_a = RegWriteM && (WA3M == RA1E) && (RA1E != PC_IDX);
  assign w_match_w_a = RegWriteW && (WA3W == RA1E) && (RA1E != PC_IDX);
  assign w_match_m_b = RegWriteM && (WA3M == RA2E) && (RA2E != PC_IDX);
  assign w_match_w_b = RegWriteW && (WA3W == RA2E) && (RA2E != PC_IDX);

  // M is the younger producer, so it wins over W.
  assign ForwardAE = w_match_m_a ? FWD_MEM : (w_match_w_a ? FWD_WB : FWD_RF);
  assign ForwardBE = w_match_m_b ? FWD_MEM : (w_match_w_b ? FWD_WB : FWD_RF);

  assign w_ld_stall = MemtoRegE && RegWriteE && (WA3E != PC_IDX) &&
                      ((WA3E == RA1D) || (WA3E == RA2D));

  mc_busy_counter #(
    .MC_LAT (MC_LAT),
    .CNT_W  (CNT_W)
  ) u_mc (
    .CLK              (CLK),
    .RST              (RST),
    .i_multi_cycle    (MultiCycleE),
    .i_branch_taken   (BranchTakenE),
    .o_busy           (w_busy),
    .o_dbg_busy_state (o_dbg_mc_busy)
  );

  // w_busy is already suppressed by a branch on the entry cycle, so checking
  // it first gives branch > hold in IDLE and hold > branch in BUSY.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (w_busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (BranchTakenE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_ld_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  assign BusyE = w_busy;

endmodule
